lif_tdm_scheduler: RTL and testbench

LIF_TDM_SCHEDULER -- requirements
Module: lif_tdm_scheduler

---
 rtl/lif_tdm_if.sv | 25 ++
 rtl/lif_tdm_scheduler.sv | 163 ++++++++++++++++
 tb/tb_lif_tdm_scheduler.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_tdm_if.sv
// Current-injection handshake and spike output bundle for lif_tdm_scheduler.
// master = injector/spike consumer, slave = scheduler.
interface lif_tdm_if #(
  parameter int N_NEURONS = 4
);
  localparam int IDW = $clog2(N_NEURONS);

  logic                 in_valid;
  logic                 in_ready;
  logic [IDW-1:0]       in_id;
  logic [7:0]           in_current;
  logic                 spike_valid;
  logic [IDW-1:0]       spike_id;
  logic [N_NEURONS-1:0] spike_vec;

  modport master (
    output in_valid, in_id, in_current,
    input  in_ready, spike_valid, spike_id, spike_vec
  );

  modport slave (
    input  in_valid, in_id, in_current,
    output in_ready, spike_valid, spike_id, spike_vec
  );
endinterface

// File: rtl/lif_tdm_scheduler.sv
// Time-multiplexed leaky integrate-and-fire array: one context evaluated per cycle per tick.
// Optional macro LIF_REFRACTORY_EN adds per-neuron refractory counters.
module lif_tdm_scheduler #(
  parameter int N_NEURONS     = 4,
  parameter int THRESHOLD     = 200,
  parameter int LEAK_SHIFT    = 1,
  parameter int REFRACT_TICKS = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tick,
  lif_tdm_if.slave                     io,
  input  logic [$clog2(N_NEURONS)-1:0] rd_id,
  output logic [7:0]                   rd_state,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);
  localparam int             IDW     = $clog2(N_NEURONS);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_NEURONS - 1);
  localparam logic [7:0]     THR     = 8'(THRESHOLD);

  if (N_NEURONS < 2 || N_NEURONS > 16 || (N_NEURONS & (N_NEURONS - 1)) != 0 ||
      THRESHOLD < 0 || THRESHOLD > 255 || LEAK_SHIFT < 0 || REFRACT_TICKS < 0) begin : g_bad_param
    $error("lif_tdm_scheduler: illegal parameter set");
  end

  typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} fsm_e;

  fsm_e                 fsm_q, fsm_d;
  logic [IDW-1:0]       idx_q, idx_d;
  logic [7:0]           mem_q [N_NEURONS];
  logic [7:0]           mem_d [N_NEURONS];
  logic [7:0]           pend_q [N_NEURONS];
  logic [7:0]           pend_d [N_NEURONS];
  logic [N_NEURONS-1:0] acc_q, acc_d;
  logic                 spike_valid_q, spike_valid_d;
  logic [IDW-1:0]       spike_id_q, spike_id_d;
  logic [N_NEURONS-1:0] spike_vec_q, spike_vec_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
  logic [7:0]           v_eval;
  logic                 fire;

`ifdef LIF_REFRACTORY_EN
  localparam int          RW   = ($clog2(REFRACT_TICKS + 1) < 1) ? 1 : $clog2(REFRACT_TICKS + 1);
  localparam logic [RW-1:0] REFR = RW'(REFRACT_TICKS);
  logic [RW-1:0] refr_q [N_NEURONS];
  logic [RW-1:0] refr_d [N_NEURONS];
`endif

  // state - leak + pending; the leak term never exceeds state, so 9 bits cannot wrap
  function automatic logic [8:0] leak_integrate(input logic [7:0] s, input logic [7:0] p);
    logic [8:0] s9;
    s9 = {1'b0, s};
    return s9 - (s9 >> LEAK_SHIFT) + {1'b0, p};
  endfunction

  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

  assign io.in_ready    = (fsm_q == S_IDLE);
  assign io.spike_valid = spike_valid_q;
  assign io.spike_id    = spike_id_q;
  assign io.spike_vec   = spike_vec_q;
  assign busy           = (fsm_q == S_SWEEP);
  assign done           = done_q;
  assign overrun        = overrun_q;
  assign rd_state       = mem_q[rd_id];

  always_comb begin
    fsm_d         = fsm_q;
    idx_d         = idx_q;
    mem_d         = mem_q;
    pend_d        = pend_q;
    acc_d         = acc_q;
    spike_valid_d = 1'b0;
    spike_id_d    = spike_id_q;
    spike_vec_d   = spike_vec_q;
    done_d        = 1'b0;
    overrun_d     = overrun_q;
    v_eval        = sat8(leak_integrate(mem_q[idx_q], pend_q[idx_q]));
    fire          = 1'b0;
`ifdef LIF_REFRACTORY_EN
    refr_d        = refr_q;
`endif
    case (fsm_q)
      S_IDLE: begin
        if (io.in_valid && io.in_ready)
          pend_d[io.in_id] = sat8({1'b0, pend_q[io.in_id]} + {1'b0, io.in_current});
        if (tick) begin
          fsm_d = S_SWEEP;
          idx_d = '0;
          acc_d = '0;
        end
      end
      S_SWEEP: begin
        if (tick) overrun_d = 1'b1;
        fire = (v_eval >= THR);
`ifdef LIF_REFRACTORY_EN
        // a refractory neuron is clamped at rest and swallows its input
        if (refr_q[idx_q] != '0) begin
          fire          = 1'b0;
          v_eval        = '0;
          refr_d[idx_q] = refr_q[idx_q] - 1'b1;
        end else if (fire) begin
          refr_d[idx_q] = REFR;
        end
`endif
        mem_d[idx_q]  = fire ? 8'd0 : v_eval;
        pend_d[idx_q] = 8'd0;
        acc_d[idx_q]  = fire;
        if (fire) begin
          spike_valid_d = 1'b1;
          spike_id_d    = idx_q;
        end
        if (idx_q == LAST_ID) begin
          fsm_d       = S_IDLE;
          done_d      = 1'b1;
          spike_vec_d = acc_d;
        end else begin
          idx_d = idx_q + IDW'(1);
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q         <= S_IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      spike_valid_q <= 1'b0;
      spike_id_q    <= '0;
      spike_vec_q   <= '0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      for (int k = 0; k < N_NEURONS; k++) begin
        mem_q[k]  <= '0;
        pend_q[k] <= '0;
`ifdef LIF_REFRACTORY_EN
        refr_q[k] <= '0;
`endif
      end
    end else begin
      fsm_q         <= fsm_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      spike_valid_q <= spike_valid_d;
      spike_id_q    <= spike_id_d;
      spike_vec_q   <= spike_vec_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      mem_q         <= mem_d;
      pend_q        <= pend_d;
`ifdef LIF_REFRACTORY_EN
      refr_q        <= refr_d;
`endif
    end
  end
endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed plus randomized bench for lif_tdm_scheduler against a per-neuron arithmetic model.
module tb_lif_tdm_scheduler;
  localparam int N   = 4;
  localparam int THR = 200;
  localparam int LS  = 1;
  localparam int RT  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] rd_id = 2'd0;
  logic [7:0] rd_state;
  logic       busy, done, overrun;

  lif_tdm_if #(.N_NEURONS(N)) bus ();

  lif_tdm_scheduler #(
    .N_NEURONS(N), .THRESHOLD(THR), .LEAK_SHIFT(LS), .REFRACT_TICKS(RT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .io(bus),
    .rd_id(rd_id), .rd_state(rd_state), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  // behavioural reference: membrane, pending charge, refractory count per neuron
  int         mstate[N];
  int         mpend[N];
  int         mrefr[N];
  bit         mspk[N];
  logic [N-1:0] mvec;
  bit         movr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mstate[k] = 0; mpend[k] = 0; mrefr[k] = 0; mspk[k] = 0;
    end
    mvec = '0;
    movr = 0;
  endtask

  task automatic model_inject(input int id, input int cur);
    mpend[id] = (mpend[id] + cur > 255) ? 255 : mpend[id] + cur;
  endtask

  task automatic model_sweep();
    int v;
    for (int k = 0; k < N; k++) begin
      v = mstate[k] - mstate[k] / (1 << LS) + mpend[k];
      if (v > 255) v = 255;
      mpend[k] = 0;
      mspk[k]  = 0;
`ifdef LIF_REFRACTORY_EN
      if (mrefr[k] > 0) begin
        mrefr[k]--;
        mstate[k] = 0;
      end else
`endif
      if (v >= THR) begin
        mspk[k]   = 1;
        mstate[k] = 0;
        mrefr[k]  = RT;
      end else begin
        mstate[k] = v;
      end
      mvec[k] = mspk[k];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic inject(input int id, input int cur);
    bus.in_valid   = 1'b1;
    bus.in_id      = id[1:0];
    bus.in_current = cur[7:0];
    chk("in_ready_idle", bus.in_ready, 1);
    model_inject(id, cur);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic check_states();
    for (int k = 0; k < N; k++) begin
      rd_id = k[1:0];
      #1;
      chk($sformatf("rd_state%0d", k), rd_state, mstate[k]);
    end
  endtask

  // Runs one sweep starting in the current (IDLE) cycle T.
  task automatic sweep(input bit inj_en, input int inj_id, input int inj_cur,
                       input int tick2_at, input bit hold, input int hv_id, input int hv_cur);
    bit es[N];
    tick = 1'b1;
    if (inj_en) begin
      bus.in_valid   = 1'b1;
      bus.in_id      = inj_id[1:0];
      bus.in_current = inj_cur[7:0];
      model_inject(inj_id, inj_cur);
    end
    model_sweep();
    for (int k = 0; k < N; k++) es[k] = mspk[k];
    step();
    tick = 1'b0;
    bus.in_valid = 1'b0;
    for (int j = 1; j <= N + 1; j++) begin
      if (j == 1 && hold) begin
        bus.in_valid   = 1'b1;
        bus.in_id      = hv_id[1:0];
        bus.in_current = hv_cur[7:0];
      end
      chk("busy", busy, (j <= N));
      chk("in_ready", bus.in_ready, (j > N));
      chk("spike_valid", bus.spike_valid, (j >= 2 && es[j-2]));
      if (j >= 2 && es[j-2]) chk("spike_id", bus.spike_id, j - 2);
      chk("done", done, (j == N + 1));
      if (j == tick2_at) begin
        tick = 1'b1;
        movr = 1;
      end
      if (j == N + 1) begin
        chk("spike_vec", bus.spike_vec, mvec);
        chk("overrun", overrun, movr);
        if (hold) model_inject(hv_id, hv_cur);
      end
      if (j <= N) begin
        step();
        tick = 1'b0;
      end
    end
    if (hold) begin
      step();
      bus.in_valid = 1'b0;
      chk("done_after", done, 0);
    end
    check_states();
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_id      = '0;
    bus.in_current = '0;
    model_reset();
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_spike_valid", bus.spike_valid, 0);
    chk("rst_spike_vec", bus.spike_vec, 0);
    rst = 1'b0;
    chk("ready_after_rst", bus.in_ready, 1);
    check_states();

    // single sub-threshold integration
    inject(0, 150);
    sweep(0, 0, 0, 0, 0, 0, 0);
    rd_id = 2'd0; #1;
    chk("req031_state0", rd_state, 150);
    chk("req031_vec", bus.spike_vec, 4'b0000);

    // leak then crossing: 150 - 75 + 150 = 225
    inject(0, 150);
    sweep(0, 0, 0, 0, 0, 0, 0);
    chk("req032_vec", bus.spike_vec, 4'b0001);

`ifdef LIF_REFRACTORY_EN
    sweep(1, 0, 250, 0, 0, 0, 0);
    chk("refr1_vec", bus.spike_vec, 4'b0000);
    sweep(1, 0, 250, 0, 0, 0, 0);
    chk("refr2_vec", bus.spike_vec, 4'b0000);
    sweep(1, 0, 250, 0, 0, 0, 0);
    chk("refr3_vec", bus.spike_vec[0], 1);
`endif

    // pending saturation and an ignored mid-sweep tick
    inject(2, 200);
    inject(2, 100);
    sweep(0, 0, 0, 2, 0, 0, 0);
    chk("req033_overrun", overrun, 1);
    chk("req033_vec2", bus.spike_vec[2], 1);

    // handshake stalls during sweep, exactly one transfer once idle
    sweep(0, 0, 0, 0, 1, 1, 80);
    sweep(0, 0, 0, 0, 0, 0, 0);

    // reset mid-sweep
    inject(3, 255);
    tick = 1'b1;
    bus.in_valid = 1'b1; bus.in_id = 2'd1; bus.in_current = 8'd255;
    step();
    tick = 1'b0;
    bus.in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_spike_valid", bus.spike_valid, 0);
    chk("midrst_spike_id", bus.spike_id, 0);
    chk("midrst_spike_vec", bus.spike_vec, 0);
    chk("midrst_ready", bus.in_ready, 1);
    step();
    rst = 1'b0;
    for (int c = 0; c < N + 2; c++) begin
      chk("postrst_done", done, 0);
      chk("postrst_spike", bus.spike_valid, 0);
      chk("postrst_busy", busy, 0);
      step();
    end
    check_states();
    sweep(1, 3, 220, 0, 0, 0, 0);

    // randomized traffic
    for (int r = 0; r < 20; r++) begin
      int ninj;
      int t2;
      ninj = $urandom_range(0, 3);
      for (int i = 0; i < ninj; i++)
        inject($urandom_range(0, N - 1), $urandom_range(0, 255));
      t2 = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N) : 0;
      sweep($urandom_range(0, 1), $urandom_range(0, N - 1), $urandom_range(0, 255),
            t2, $urandom_range(0, 4) == 0, $urandom_range(0, N - 1), $urandom_range(0, 255));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
